// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequences an external single-cycle ALU through shift-and-add
// iterations to form the low 32 bits of an unsigned a*b.
// Build option MUL_EARLY_EXIT_EN: when defined, the loop stops as soon as the
// remaining multiplier is zero. Otherwise a 6-bit iteration counter forces all
// 32 bits to be processed, which gives a data-independent loop count.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [5:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_res
);

  localparam logic [5:0] OP_ADD = 6'b100_000;
  localparam logic [5:0] OP_SLL = 6'b000_000;
  localparam logic [5:0] OP_SRL = 6'b000_010;
  localparam logic [5:0] OP_NOP = 6'b111_111;

  typedef enum logic [2:0] {
    S_IDLE, S_TEST, S_ADD, S_SHL, S_SHR, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] result_q, result_d;
  logic        iter_done;

`ifdef MUL_EARLY_EXIT_EN
  // Nothing left to add once every remaining multiplier bit is zero.
  assign iter_done = (mplier_q == '0);
`else
  logic [5:0] cnt_q, cnt_d;
  // Exit only after all 32 multiplier bits have been shifted out.
  assign iter_done = (cnt_q == 6'd32);
`endif

  // State register and datapath flops, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
`ifndef MUL_EARLY_EXIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
`ifndef MUL_EARLY_EXIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state and register-update logic; ALU results land on the same edge.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
`ifndef MUL_EARLY_EXIT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          result_d = '0;
`ifndef MUL_EARLY_EXIT_EN
          cnt_d    = '0;
`endif
          state_d  = S_TEST;
        end
      end
      S_TEST: begin
        if (iter_done)        state_d = S_DONE;
        else if (mplier_q[0]) state_d = S_ADD;
        else                  state_d = S_SHL;
      end
      S_ADD: begin
        acc_d   = alu_res;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = alu_res;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = alu_res;
`ifndef MUL_EARLY_EXIT_EN
        cnt_d    = cnt_q + 6'd1;
`endif
        state_d  = S_TEST;
      end
      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: handshake and ALU request decoded from state and registers.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
    alu_opA   = '0;
    alu_opB   = '0;
    alu_op    = OP_NOP;
    alu_shamt = '0;
    case (state_q)
      S_ADD: begin
        alu_opA = acc_q;
        alu_opB = mcand_q;
        alu_op  = OP_ADD;
      end
      S_SHL: begin
        alu_opB   = mcand_q;
        alu_op    = OP_SLL;
        alu_shamt = 5'd1;
      end
      S_SHR: begin
        alu_opB   = mplier_q;
        alu_op    = OP_SRL;
        alu_shamt = 5'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed checks of alu_mul_seq against a
// behavioural model (a*b mod 2^32, closed-form latency) with a simple ALU.
module tb_alu_mul_seq;

  localparam logic [5:0] OP_ADD = 6'b100_000;
  localparam logic [5:0] OP_SLL = 6'b000_000;
  localparam logic [5:0] OP_SRL = 6'b000_010;
  localparam logic [5:0] OP_NOP = 6'b111_111;
  localparam int         MAXCYC = 200;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result, alu_opA, alu_opB, alu_res;
  logic [5:0]  alu_op;
  logic [4:0]  alu_shamt;

  int total = 0;
  int bad   = 0;

  // Observations from the last operation run by do_op.
  int          lat;
  logic [31:0] res;
  bit          to, add_seen, busy_gap;
  logic [5:0]  op_log[$];

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_op(alu_op),
    .alu_shamt(alu_shamt), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  // Environment ALU.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD: alu_res = alu_opA + alu_opB;
      OP_SLL: alu_res = alu_opB << alu_shamt;
      OP_SRL: alu_res = alu_opB >> alu_shamt;
      default: alu_res = '0;
    endcase
  end

  // Reference model.
  function automatic logic [31:0] exp_prod(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [31:0] y);
    int pop;
    int k;
    pop = $countones(y);
    k = -1;
    for (int i = 0; i < 32; i++) if (y[i]) k = i;
`ifdef MUL_EARLY_EXIT_EN
    return 2 + 3 * (k + 1) + pop;
`else
    return 98 + pop;
`endif
  endfunction

  // Starts an operation from a negedge in IDLE; returns at the negedge of the
  // first IDLE cycle after DONE with the result sampled there.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib);
    int cyc;
    op_log.delete();
    to = 0; add_seen = 0; busy_gap = 0; lat = -1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    while (!done && cyc < MAXCYC) begin
      op_log.push_back(alu_op);
      if (alu_op == OP_ADD) add_seen = 1;
      if (!busy) busy_gap = 1;
      @(negedge clk);
      cyc++;
    end
    if (!done) to = 1;
    else begin
      lat = cyc;
      if (!busy) busy_gap = 1;
      @(negedge clk);
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%0h exp=0", result); end
    total++; if (alu_op !== OP_NOP) begin bad++; $display("FAIL reset_op got=%0h exp=%0h", alu_op, OP_NOP); end
    total++; if ({alu_opA, alu_opB, alu_shamt} !== '0) begin bad++; $display("FAIL reset_operands got=%0h exp=0", {alu_opA, alu_opB, alu_shamt}); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // b = 0: no ADD ever issued.
    do_op(32'd7, 32'd0);
    total++; if (to || lat != exp_lat(32'd0)) begin bad++; $display("FAIL b0_latency got=%0d exp=%0d", lat, exp_lat(32'd0)); end
    total++; if (res !== 32'd0) begin bad++; $display("FAIL b0_result got=%0h exp=0", res); end
    total++; if (add_seen) begin bad++; $display("FAIL b0_no_add got=1 exp=0"); end
    // b = 1: opcode order through one iteration.
    do_op(32'd5, 32'd1);
    total++; if (to || lat != exp_lat(32'd1)) begin bad++; $display("FAIL b1_latency got=%0d exp=%0d", lat, exp_lat(32'd1)); end
    total++; if (res !== 32'd5) begin bad++; $display("FAIL b1_result got=%0h exp=5", res); end
    total++;
    if (op_log.size() < 5 || op_log[0] !== OP_NOP || op_log[1] !== OP_ADD ||
        op_log[2] !== OP_SLL || op_log[3] !== OP_SRL || op_log[4] !== OP_NOP) begin
      bad++;
      $display("FAIL b1_op_seq got_len=%0d exp=NOP,ADD,SLL,SRL,NOP", op_log.size());
    end
    // b = 3.
    do_op(32'h1234_5678, 32'd3);
    total++; if (to || lat != exp_lat(32'd3)) begin bad++; $display("FAIL b3_latency got=%0d exp=%0d", lat, exp_lat(32'd3)); end
    total++; if (res !== 32'h369D_0368) begin bad++; $display("FAIL b3_result got=%0h exp=369d0368", res); end
    // All ones: wraps, longest run, busy throughout.
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (to || lat != exp_lat(32'hFFFF_FFFF)) begin bad++; $display("FAIL ones_latency got=%0d exp=%0d", lat, exp_lat(32'hFFFF_FFFF)); end
    total++; if (res !== 32'h0000_0001) begin bad++; $display("FAIL ones_result got=%0h exp=1", res); end
    total++; if (busy_gap) begin bad++; $display("FAIL ones_busy got=gap exp=continuous"); end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_op(ra, rb);
      total++;
      if (to || lat != exp_lat(rb)) begin bad++; $display("FAIL rand_latency a=%0h b=%0h got=%0d exp=%0d", ra, rb, lat, exp_lat(rb)); end
      total++;
      if (res !== exp_prod(ra, rb)) begin bad++; $display("FAIL rand_result a=%0h b=%0h got=%0h exp=%0h", ra, rb, res, exp_prod(ra, rb)); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // a=3,b=5 with a stray start at cycle 4 that must be ignored.
    a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < MAXCYC) begin
      if (cyc == 4) begin start = 1'b1; a = 32'd99; b = 32'd99; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++; if (!done || cyc != exp_lat(32'd5)) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, exp_lat(32'd5)); end
    @(negedge clk);
    total++; if (result !== 32'd15) begin bad++; $display("FAIL b2b_first_result got=%0h exp=f", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%0b exp=0", busy); end
    // Immediate restart in the first IDLE cycle.
    do_op(32'd2, 32'd2);
    total++; if (to || lat != exp_lat(32'd2)) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, exp_lat(32'd2)); end
    total++; if (res !== 32'd4) begin bad++; $display("FAIL b2b_second_result got=%0h exp=4", res); end
  endtask

  task automatic test_mid_reset();
    int dones;
    a = 32'd9; b = 32'hFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);                  // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);       // cycle 5
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%0b exp=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL mrst_result got=%0h exp=0", result); end
    total++; if (alu_op !== OP_NOP) begin bad++; $display("FAIL mrst_op got=%0h exp=%0h", alu_op, OP_NOP); end
    rst = 1'b0;
    dones = 0;
    repeat (MAXCYC) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL mrst_no_done got=%0d exp=0", dones); end
    // Recovers cleanly afterwards.
    do_op(32'd6, 32'd7);
    total++; if (to || res !== 32'd42) begin bad++; $display("FAIL mrst_recover got=%0h exp=2a", res); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiplier controller that sequences the shared single-cycle ALU through shift-and-add iterations. It owns no arithmetic of its own; every add and shift is issued to the external combinational ALU via alu_op/opA/opB/shamt, and the result is captured on the same clock edge. It sits beside the ALU in the execute stage and delivers the low 32 bits of a×b with a start/busy/done handshake.

## Interface
- OP_ADD, 6'b100_000, ALU function code for add
- OP_SLL, 6'b000_000, ALU function code for logical left shift of opB by shamt
- OP_SRL, 6'b000_010, ALU function code for logical right shift of opB by shamt
- OP_NOP, 6'b111_111, code driven when the ALU is not in use; the ALU returns 0 for it
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  multiplicand, captured when start is accepted
- b  input  32  multiplier, captured when start is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  32  product mod 2^32; holds until next accepted start
- alu_opA  output  32  ALU operand A
- alu_opB  output  32  ALU operand B
- alu_op  output  6  ALU function select
- alu_shamt  output  5  ALU shift amount
- alu_res  input  32  ALU combinational result

## Operation
- Registers: acc (32), mcand (32), mplier (32), state.
- States: IDLE, TEST, ADD, SHL, SHR, DONE.
- IDLE: start=1 → acc=0, mcand=a, mplier=b, result=0 → TEST. start=0 → stay.
- TEST (no ALU use): mplier==0 → DONE. Otherwise mplier[0]=1 → ADD, else → SHL.
- ADD: opA=acc, opB=mcand, op=OP_ADD, shamt=0; acc<=alu_res → SHL.
- SHL: opA=0, opB=mcand, op=OP_SLL, shamt=1; mcand<=alu_res → SHR.
- SHR: opA=0, opB=mplier, op=OP_SRL, shamt=1; mplier<=alu_res → TEST.
- DONE: done=1, result<=acc (visible from the next cycle) → IDLE.
- In IDLE, TEST, and DONE, drive opA=0, opB=0, op=OP_NOP, shamt=0.
- ALU-side outputs are combinational from state and registers (Moore-style). busy is decoded from state.
- Arithmetic: unsigned. Overflow beyond bit 31 is discarded silently, so the product wraps mod 2^32.
- start while busy: ignored, with no queuing. a and b are don't-care after acceptance.
- Reset (including mid-operation): state=IDLE, acc=mcand=mplier=0, result=0, busy=0, done=0, op=OP_NOP.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE. TEST is cycle 1.
- k is the index of the highest set bit of b. Latency from start edge to the DONE cycle is 2 + 3·(k+1) + popcount(b).
- b=0 gives a latency of 2 cycles.
- Maximum latency is 130 cycles (b=0xFFFF_FFFF).
- result updates on the edge leaving DONE. done and the new result are therefore offset by one cycle. The bench samples result when done falls (first IDLE cycle).
- Back-to-back: start may be high in the IDLE cycle right after DONE. Minimum spacing between starts is latency + 1.

## Configuration
- MUL_EARLY_EXIT_EN defined: TEST exits on mplier==0 (latency as above).
- MUL_EARLY_EXIT_EN undefined: adds a 6-bit iteration counter, cleared on start and incremented in SHR. TEST exits only when the counter reaches 32, so all 32 bits are processed. Latency is fixed at 98 + popcount(b), with b=0 giving 98. Results are identical in both builds.

## Test plan
- a=7, b=0, start one cycle → done in cycle 2, result=0, no ADD issued (alu_op never 6'b100_000).
- a=5, b=1 → alu_op sequence NOP, ADD, SLL, SRL, NOP; done in cycle 6; result=5.
- a=0x1234_5678, b=3 → result=0x369D_0368, latency 2+6+2=10 (early-exit build); 100 in the no-exit build.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF → result=0x0000_0001 (wrap), latency 130; busy high throughout.
- start pulsed again at cycle 4 of an a=3, b=5 operation → ignored; result=15. A second start in the first IDLE cycle with a=2, b=2 → result=4.
- rst asserted in cycle 5 of a=9, b=0xFF → next cycle busy=0, done=0, result=0, alu_op=6'b111_111. No done pulse follows.
